// File: rtl/i2c_rx_fsm_p_if.sv
// Bus between the SCL/SDA edge detector, the I2C receive controller and the loader.
// The detector side uses master and the receive controller uses slave.
interface i2c_rx_fsm_p_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4
);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  logic              start_in;
  logic              stop_in;
  logic              scl_rise_in;
  logic              scl_fall_in;
  logic              sda_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [CNT_W-1:0]  byte_cnt_out;
  logic              oe_out;
  logic              clr_out;
  logic              frame_done_out;
  logic              nack_out;
  logic              busy_out;

  modport master (
    output start_in, stop_in, scl_rise_in, scl_fall_in, sda_in,
    input  data_out, valid_out, byte_cnt_out, oe_out, clr_out,
           frame_done_out, nack_out, busy_out
  );

  modport slave (
    input  start_in, stop_in, scl_rise_in, scl_fall_in, sda_in,
    output data_out, valid_out, byte_cnt_out, oe_out, clr_out,
           frame_done_out, nack_out, busy_out
  );
endinterface

// File: rtl/i2c_rx_fsm_p.sv
// I2C slave receive controller: optional address phase, DATA_W-bit data bytes,
// up to MAX_BYTES bytes per frame, ACK pull-down on SDA via oe_out.
//
// state      | meaning
// S_IDLE     | bus idle, waiting for START
// S_ADDR     | shifting in 7-bit address + R/W
// S_ADDR_ACK | two-fall window driving the address ACK
// S_DATA     | shifting in a data byte
// S_DATA_ACK | two-fall window driving the data ACK
// S_IGNORE   | NACKed frame, waiting for STOP or START
module i2c_rx_fsm_p #(
  parameter int         DATA_W    = 8,
  parameter int         MAX_BYTES = 4,
  parameter int         ADDR_EN   = 1,
  parameter logic [6:0] DEV_ADDR  = 7'h2A
) (
  input  logic           clk,
  input  logic           rst,
  i2c_rx_fsm_p_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  // Holds all but the newest bit; wide enough for the 8-bit address byte.
  localparam int SW = (DATA_W > 8) ? DATA_W : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  localparam state_t S_FIRST = (ADDR_EN != 0) ? S_ADDR : S_DATA;

  state_t            state_q, state_d;
  logic [SW-2:0]     shift_q, shift_d;
  logic [4:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              oe_q, oe_d;
  logic              valid_q, valid_d;
  logic              clr_q, clr_d;
  logic              fd_q, fd_d;
  logic              nack_q, nack_d;

  logic [7:0]        addr_byte;
  logic [DATA_W-1:0] data_byte;
  logic [SW-2:0]     shift_next;

  assign addr_byte  = {shift_q[6:0], bus.sda_in};
  assign data_byte  = {shift_q[DATA_W-2:0], bus.sda_in};
  assign shift_next = {shift_q[SW-3:0], bus.sda_in};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    valid_d = 1'b0;
    clr_d   = 1'b0;
    fd_d    = 1'b0;
    nack_d  = 1'b0;

    if (bus.stop_in) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        clr_d   = 1'b1;
        oe_d    = 1'b0;
        fd_d    = (cnt_q != '0);
      end
    end else if (bus.start_in) begin
      clr_d   = (state_q != S_IDLE);
      state_d = S_FIRST;
      bit_d   = '0;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (bus.scl_rise_in) begin
            shift_d = shift_next;
            bit_d   = bit_q + 5'd1;
            if (bit_q == 5'd7) begin
              if (addr_byte[7:1] == DEV_ADDR && !addr_byte[0]) begin
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IGNORE;
                nack_d  = 1'b1;
              end
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First fall opens the ACK bit, second fall closes it.
          if (bus.scl_fall_in && !bus.scl_rise_in) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
        end
        S_DATA: begin
          if (bus.scl_rise_in) begin
            shift_d = shift_next;
            bit_d   = bit_q + 5'd1;
            if (bit_q == 5'(DATA_W - 1)) begin
              if (cnt_q < CNT_W'(MAX_BYTES)) begin
                data_d  = data_byte;
                valid_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_DATA_ACK;
              end else begin
                nack_d  = 1'b1;
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_IGNORE: oe_d = 1'b0;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      fd_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
      fd_q    <= fd_d;
      nack_q  <= nack_d;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.valid_out      = valid_q;
  assign bus.byte_cnt_out   = cnt_q;
  assign bus.oe_out         = oe_q;
  assign bus.clr_out        = clr_q;
  assign bus.frame_done_out = fd_q;
  assign bus.nack_out       = nack_q;
  assign bus.busy_out       = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_rx_fsm_p.sv
// Bench for i2c_rx_fsm_p: default-config DUT (A) and a legacy 12-bit DUT (B)
// share one stimulus bus; sel picks whose outputs are checked.
module tb_i2c_rx_fsm_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, rise, fall, sda;
  bit   sel;

  i2c_rx_fsm_p_if #(.DATA_W(8),  .MAX_BYTES(4)) if_a ();
  i2c_rx_fsm_p_if #(.DATA_W(12), .MAX_BYTES(4)) if_b ();

  assign if_a.start_in = start;  assign if_b.start_in = start;
  assign if_a.stop_in  = stop;   assign if_b.stop_in  = stop;
  assign if_a.scl_rise_in = rise; assign if_b.scl_rise_in = rise;
  assign if_a.scl_fall_in = fall; assign if_b.scl_fall_in = fall;
  assign if_a.sda_in   = sda;    assign if_b.sda_in   = sda;

  i2c_rx_fsm_p #(.DATA_W(8), .MAX_BYTES(4), .ADDR_EN(1), .DEV_ADDR(7'h2A))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  i2c_rx_fsm_p #(.DATA_W(12), .MAX_BYTES(4), .ADDR_EN(0), .DEV_ADDR(7'h2A))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  logic [15:0] data_sel;
  logic [2:0]  cnt_sel;
  logic        valid_sel, oe_sel, clr_sel, fd_sel, nack_sel, busy_sel;
  assign data_sel  = sel ? 16'(if_b.data_out) : 16'(if_a.data_out);
  assign cnt_sel   = sel ? if_b.byte_cnt_out : if_a.byte_cnt_out;
  assign valid_sel = sel ? if_b.valid_out : if_a.valid_out;
  assign oe_sel    = sel ? if_b.oe_out : if_a.oe_out;
  assign clr_sel   = sel ? if_b.clr_out : if_a.clr_out;
  assign fd_sel    = sel ? if_b.frame_done_out : if_a.frame_done_out;
  assign nack_sel  = sel ? if_b.nack_out : if_a.nack_out;
  assign busy_sel  = sel ? if_b.busy_out : if_a.busy_out;

  // Pulse counters, sampled mid-cycle.
  int n_valid = 0, n_nack = 0, n_clr = 0, n_fd = 0;
  always @(negedge clk) begin
    n_valid <= n_valid + int'(valid_sel);
    n_nack  <= n_nack  + int'(nack_sel);
    n_clr   <= n_clr   + int'(clr_sel);
    n_fd    <= n_fd    + int'(fd_sel);
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_last = '0;

  typedef struct {
    logic [7:0]      addr;
    int              nbytes;
    logic [4:0][7:0] d;
    int              n_valid;
    int              n_nack;
    int              fd;
    int              cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0; cyc();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
  endtask

  // Shift n bits MSB first, optionally followed by the ACK clock.
  task automatic send_bits(input logic [15:0] v, input int n, input bit exp_ack,
                           input bit exp_valid, input bit ack_clk);
    logic [15:0] e;
    for (int i = n - 1; i >= 0; i--) begin
      sda = v[i]; cyc();
      rise = 1'b1; cyc(); rise = 1'b0;
      if (i == 0) begin
        chk("valid_latency", valid_sel, exp_valid);
        chk("oe_before_fall", oe_sel, 0);
        if (valid_sel) begin
          if (sb.size() == 0) chk("valid_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("data_out", data_sel, e);
          end
        end
      end
      cyc();
      fall = 1'b1; cyc(); fall = 1'b0;
      if (i == 0) chk("ack_oe", oe_sel, exp_ack);
      cyc();
    end
    if (ack_clk) begin
      sda = 1'b1; cyc();
      rise = 1'b1; cyc(); rise = 1'b0; cyc();
      fall = 1'b1; cyc(); fall = 1'b0;
      chk("ack_release", oe_sel, 0);
      cyc();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int v0, k0, c0, f0;
    bit ok, acc;
    v0 = n_valid; k0 = n_nack; c0 = n_clr; f0 = n_fd;
    ok = (v.addr[7:1] == 7'h2A) && !v.addr[0];
    pulse_start();
    chk("busy_after_start", busy_sel, 1);
    send_bits({8'h00, v.addr}, 8, ok, 1'b0, 1'b1);
    for (int i = 0; i < v.nbytes; i++) begin
      acc = ok && (i < 4);
      if (acc) begin
        sb.push_back({8'h00, v.d[i]});
        exp_last = {8'h00, v.d[i]};
      end
      send_bits({8'h00, v.d[i]}, 8, acc, acc, 1'b1);
    end
    pulse_stop();
    chk("frame_valid_cnt", n_valid - v0, v.n_valid);
    chk("frame_nack_cnt", n_nack - k0, v.n_nack);
    chk("frame_clr_cnt", n_clr - c0, 1);
    chk("frame_done_cnt", n_fd - f0, v.fd);
    chk("byte_cnt_out", cnt_sel, v.cnt);
    chk("data_out_held", data_sel, exp_last);
    chk("busy_after_stop", busy_sel, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int v0, c0, f0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; rise = 1'b0; fall = 1'b0; sda = 1'b1;
    sel = 1'b0;

    vecs[0] = '{8'h54, 2, {8'h00, 8'h00, 8'h00, 8'h3C, 8'hA5}, 2, 0, 1, 2};
    vecs[1] = '{8'h56, 2, {8'h00, 8'h00, 8'h00, 8'h12, 8'h34}, 0, 1, 0, 0};
    vecs[2] = '{8'h55, 2, {8'h00, 8'h00, 8'h00, 8'h56, 8'h78}, 0, 1, 0, 0};
    vecs[3] = '{8'h54, 5, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 4, 1, 1, 4};
    vecs[4] = '{8'h54, 4, {8'h00, 8'hFF, 8'h00, 8'h55, 8'hAA}, 4, 0, 1, 4};
    vecs[5] = '{8'h54, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0, 0};

    repeat (3) cyc();
    start = 1'b1;
    cyc();
    chk("rst_overrides_start", busy_sel, 0);
    start = 1'b0; rst = 1'b0;
    cyc();
    chk("rst_data", data_sel, 0);
    chk("rst_cnt", cnt_sel, 0);
    chk("rst_oe", oe_sel, 0);
    chk("rst_busy", busy_sel, 0);
    chk("rst_valid", valid_sel, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // STOP mid-byte, then a repeated START mid-byte after an accepted byte.
    v0 = n_valid; c0 = n_clr; f0 = n_fd;
    pulse_start();
    send_bits(16'h0054, 8, 1'b1, 1'b0, 1'b1);
    sb.push_back(16'h0011); exp_last = 16'h0011;
    send_bits(16'h0011, 8, 1'b1, 1'b1, 1'b1);
    send_bits(16'h0005, 3, 1'b0, 1'b0, 1'b0);
    pulse_stop();
    chk("part_stop_valid", n_valid - v0, 1);
    chk("part_stop_clr", n_clr - c0, 1);
    chk("part_stop_fd", n_fd - f0, 1);
    chk("part_stop_data", data_sel, 16'h0011);
    chk("part_stop_cnt_held", cnt_sel, 1);
    pulse_start();
    chk("cnt_cleared_on_start", cnt_sel, 0);
    send_bits(16'h0054, 8, 1'b1, 1'b0, 1'b1);
    sb.push_back(16'h0022); exp_last = 16'h0022;
    send_bits(16'h0022, 8, 1'b1, 1'b1, 1'b1);
    send_bits(16'h0003, 3, 1'b0, 1'b0, 1'b0);
    v0 = n_valid; c0 = n_clr; f0 = n_fd;
    pulse_start();
    chk("rstart_clr", n_clr - c0, 1);
    chk("rstart_no_fd", n_fd - f0, 0);
    chk("rstart_cnt", cnt_sel, 0);
    chk("rstart_busy", busy_sel, 1);
    chk("rstart_data", data_sel, 16'h0022);
    send_bits(16'h0054, 8, 1'b1, 1'b0, 1'b1);
    sb.push_back(16'h0077); exp_last = 16'h0077;
    send_bits(16'h0077, 8, 1'b1, 1'b1, 1'b1);
    chk("rstart_cnt_after", cnt_sel, 1);
    pulse_stop();
    chk("rstart_valid", n_valid - v0, 1);
    chk("rstart_fd_stop", n_fd - f0, 1);
    chk("rstart_data_final", data_sel, 16'h0077);

    // Legacy 12-bit DUT.
    sel = 1'b1;
    cyc();
    v0 = n_valid; c0 = n_clr; f0 = n_fd;
    pulse_start();
    chk("b_busy", busy_sel, 1);
    sb.push_back(16'h0ABC);
    send_bits(16'h0ABC, 12, 1'b1, 1'b1, 1'b1);
    chk("b_cnt", cnt_sel, 1);
    pulse_stop();
    chk("b_valid_cnt", n_valid - v0, 1);
    chk("b_clr", n_clr - c0, 1);
    chk("b_fd", n_fd - f0, 1);
    chk("b_data", data_sel, 16'h0ABC);
    sel = 1'b0;
    cyc();

    // Reset inside the data ACK window with oe_out asserted.
    pulse_start();
    send_bits(16'h0054, 8, 1'b1, 1'b0, 1'b1);
    sb.push_back(16'h005A);
    send_bits(16'h005A, 8, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_oe", oe_sel, 1);
    rst = 1'b1; cyc();
    chk("ack_rst_oe", oe_sel, 0);
    chk("ack_rst_busy", busy_sel, 0);
    chk("ack_rst_data", data_sel, 0);
    chk("ack_rst_cnt", cnt_sel, 0);
    rst = 1'b0; exp_last = '0;
    cyc();

    // START and STOP together while busy behave as STOP.
    pulse_start();
    send_bits(16'h0054, 8, 1'b1, 1'b0, 1'b1);
    chk("ss_busy_before", busy_sel, 1);
    c0 = n_clr; f0 = n_fd;
    start = 1'b1; stop = 1'b1; cyc();
    start = 1'b0; stop = 1'b0; cyc();
    chk("ss_busy_after", busy_sel, 0);
    chk("ss_clr", n_clr - c0, 1);
    chk("ss_no_fd", n_fd - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
